store_write_ctrl: RTL
=====================

Name: store_write_ctrl

Overview:
- Write-side controller that drives the memory write port (wr_en byte-enables, wr_addr, wr_data) from store requests issued by the execute/memory stage.
- Converts a byte, halfword or word store at any byte address into word-aligned write beats.
- Splits word-crossing (misaligned) stores into two beats.
- Flags reserved sizes and provides a valid/ready handshake toward the pipeline.

Parameters:
- DATA_WIDTH, 32, width of wr_data and req_data; must equal 8*WR_EN_WIDTH
- ADDR_WIDTH, 32, width of req_addr and wr_addr (byte address)
- WR_EN_WIDTH, 4, number of byte-enable bits

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  controller can accept a request this cycle
- req_addr  input  ADDR_WIDTH  byte address of store
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_data  input  DATA_WIDTH  store data, right-justified (rs2)
- wr_en  output  WR_EN_WIDTH  byte-enables to memory, one bit per byte lane
- wr_addr  output  ADDR_WIDTH  word-aligned write address (low 2 bits always 0)
- wr_data  output  DATA_WIDTH  lane-shifted write data
- done  output  1  one-cycle pulse on the final beat of each accepted request
- err  output  1  valid with done; 1 = reserved size, no write performed

Behaviour:
- Clock, reset and polarity: one clock (clk); reset rst_n is synchronous and active-low.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, done=0, err=0. State=IDLE.
- All memory-side outputs and done/err are registered.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - req_addr, req_size and req_data are captured at acceptance and need not be held afterward.
- States: IDLE, BEAT1, BEAT2.
  - Acceptance from any state → BEAT1 next cycle.
  - BEAT1 with split → BEAT2.
  - BEAT1 without split, or BEAT2, with no new acceptance → IDLE.
- req_ready = 0 only in BEAT1 when the captured request is split; 1 otherwise. Single-beat stores therefore sustain one per cycle; split stores take two cycles.
- Beat computation, with off = addr[1:0], nbytes = 1/2/4 for size 00/01/10, mask = (1<<nbytes)-1 (4 bits):
  - split = (off + nbytes > 4).
  - BEAT1: wr_addr = addr with low 2 bits cleared; wr_en = (mask << off)[3:0]; wr_data = (data << 8*off) truncated to DATA_WIDTH.
  - BEAT2: wr_addr = BEAT1 address + 4, modulo 2^ADDR_WIDTH (0xFFFFFFFC wraps to 0x00000000); wr_en = mask >> (4-off); wr_data = data >> 8*(4-off).
  - Bytes of req_data above nbytes are ignored (masked off before shifting).
- done=1, err=0 in the last beat cycle: BEAT1 if not split, BEAT2 if split.
- Reserved size (11): accepted normally, never split. In BEAT1, wr_en=0 with done=1 and err=1. wr_addr/wr_data are unspecified-but-stable (hold previous values).
- Idle cycles: wr_en=0, done=0, err=0; wr_addr and wr_data hold their last values.
- Reset mid-operation (BEAT1 or BEAT2): state→IDLE and all outputs go to reset values on that edge. The pending second beat is discarded and no done is issued.
- Latency: first write beat and done appear exactly one cycle after acceptance (two cycles for done on split stores).

Test Plan:
- SW addr=0x100, data=0xDEADBEEF → next cycle wr_addr=0x100, wr_en=1111, wr_data=0xDEADBEEF, done=1, err=0; req_ready stays 1.
- SB addr=0x203, data=0x123456AB → wr_addr=0x200, wr_en=1000, wr_data=0xAB000000, done=1. Back-to-back SH addr=0x206, data=0xCAFE next cycle → wr_addr=0x204, wr_en=1100, wr_data=0xCAFE0000.
- SW addr=0x301, data=0xAABBCCDD (split) → cycle 1: wr_addr=0x300, wr_en=1110, wr_data=0xBBCCDD00, done=0, req_ready=0. Cycle 2: wr_addr=0x304, wr_en=0001, wr_data=0x000000AA, done=1.
- SH addr=0xFFFFFFFF, data=0x1122 → beat 1: wr_addr=0xFFFFFFFC, wr_en=1000, wr_data=0x22000000. Beat 2: wr_addr=0x00000000, wr_en=0001, wr_data=0x00000011, done=1.
- req_size=11, addr=0x40 → next cycle wr_en=0000, done=1, err=1; following idle cycle done=0, err=0.
- Split SW addr=0x502, then rst_n=0 asserted during beat 1 → next edge wr_en=0, done=0, state IDLE, req_ready=1. No beat to 0x504 ever appears.

Source files
------------

// File: rtl/store_write_ctrl.sv
// Store write-side controller: turns byte/halfword/word stores at any byte
// address into one or two word-aligned, byte-enabled memory write beats.
module store_write_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WR_EN_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [1:0]             req_size,
  input  logic [DATA_WIDTH-1:0]  req_data,
  output logic [WR_EN_WIDTH-1:0] wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   done,
  output logic                   err
);

  localparam int OFF_W = $clog2(WR_EN_WIDTH);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_e;

  state_e                 state_q;
  logic                   split_q;
  logic [WR_EN_WIDTH-1:0] wr_en_q, b2_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, b2_addr_q;
  logic [DATA_WIDTH-1:0]  wr_data_q, b2_data_q;
  logic                   done_q, err_q;

  logic                   accept;
  logic [OFF_W-1:0]       off;
  int                     nbytes;
  logic [WR_EN_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0]  data_m;
  logic                   split_d, rsvd_d;
  logic [ADDR_WIDTH-1:0]  b1_addr_d, b2_addr_d;
  logic [WR_EN_WIDTH-1:0] b1_en_d, b2_en_d;
  logic [DATA_WIDTH-1:0]  b1_data_d, b2_data_d;

  // Only the first beat of a split store blocks the pipeline.
  assign req_ready = !((state_q == BEAT1) && split_q);
  assign accept    = req_valid && req_ready;

  // Both beats are derived at acceptance so the request need not be held.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    nbytes = 0;
    mask   = '0;
    data_m = '0;
    off    = req_addr[OFF_W-1:0];
    rsvd_d = (req_size == 2'b11);
    case (req_size)
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      2'b10:   nbytes = 4;
      default: nbytes = 0;
    endcase
    for (int i = 0; i < WR_EN_WIDTH; i++) begin
      mask[i]        = (i < nbytes);
      data_m[8*i +: 8] = mask[i] ? req_data[8*i +: 8] : 8'h00;
    end
    split_d   = (int'(off) + nbytes) > WR_EN_WIDTH;
    b1_addr_d = {req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
    b2_addr_d = b1_addr_d + ADDR_WIDTH'(WR_EN_WIDTH);
    b1_en_d   = mask << off;
    b1_data_d = data_m << (8 * int'(off));
    b2_en_d   = mask >> (WR_EN_WIDTH - int'(off));
    b2_data_d = data_m >> (8 * (WR_EN_WIDTH - int'(off)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      split_q   <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      b2_en_q   <= '0;
      b2_addr_q <= '0;
      b2_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if ((state_q == BEAT1) && split_q) begin
        state_q   <= BEAT2;
        wr_en_q   <= b2_en_q;
        wr_addr_q <= b2_addr_q;
        wr_data_q <= b2_data_q;
        done_q    <= 1'b1;
      end else if (accept) begin
        state_q   <= BEAT1;
        split_q   <= split_d && !rsvd_d;
        b2_en_q   <= b2_en_d;
        b2_addr_q <= b2_addr_d;
        b2_data_q <= b2_data_d;
        if (rsvd_d) begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end else begin
          wr_en_q   <= b1_en_d;
          wr_addr_q <= b1_addr_d;
          wr_data_q <= b1_data_d;
          done_q    <= !split_d;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
